// File: rtl/pair_sort_loader.sv
// pair_sort_loader
// ----------------------------------------------------------------------------
// Upstream feeder for the 2-to-4 odd-even merge stage. Accepts a serial stream
// of unsigned samples and groups every four accepted samples into two
// ascending pairs. The pairs are presented in parallel to the merge stage.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps data stable while valid
// is high and ready is low. ready never depends on the same port's valid.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of the partial group and any held output
//   in_data    incoming sample (WIDTH bits, unsigned)
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   out_a      sorted pair A: [WIDTH-1:0]=min(s0,s1), [2*WIDTH-1:WIDTH]=max(s0,s1)
//   out_b      sorted pair B: [WIDTH-1:0]=min(s2,s3), [2*WIDTH-1:WIDTH]=max(s2,s3)
//   out_valid  out_a/out_b hold a complete group
//   out_ready  downstream consumes the group this cycle
// ----------------------------------------------------------------------------
module pair_sort_loader #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] out_a,
    output logic [2*WIDTH-1:0] out_b,
    output logic               out_valid,
    input  logic               out_ready
);

    // Number of samples of the current group already taken.
    typedef enum logic [1:0] {
        CNT_0 = 2'd0,
        CNT_1 = 2'd1,
        CNT_2 = 2'd2,
        CNT_3 = 2'd3
    } cnt_t;

    cnt_t               r_cnt;
    cnt_t               w_cnt_nxt;
    logic [WIDTH-1:0]   r_pend;
    logic [WIDTH-1:0]   w_pend_nxt;
    logic [2*WIDTH-1:0] r_out_a;
    logic [2*WIDTH-1:0] w_out_a_nxt;
    logic [2*WIDTH-1:0] r_out_b;
    logic [2*WIDTH-1:0] w_out_b_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;

    // Input is blocked only while a group is held and not being consumed.
    // Because cnt is 0 whenever a group is held, an accept during HOLD can
    // only be the first sample of the next group, which never touches out_a/b.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready;

    // Unsigned compare-exchange of the pending sample with the new one.
    assign w_lo = (r_pend < in_data) ? r_pend : in_data;
    assign w_hi = (r_pend < in_data) ? in_data : r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= CNT_0;
            r_pend      <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_out_a     <= w_out_a_nxt;
            r_out_b     <= w_out_b_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_pend_nxt      = r_pend;
        w_out_a_nxt     = r_out_a;
        w_out_b_nxt     = r_out_b;
        w_out_valid_nxt = r_out_valid;

        if (clear) begin
            // Flush wins over any accept or transfer in the same cycle;
            // the presented sample is dropped and output data may stay stale.
            w_cnt_nxt       = CNT_0;
            w_out_valid_nxt = 1'b0;
        end else begin
            if (w_xfer) begin
                w_out_valid_nxt = 1'b0;
            end
            if (w_accept) begin
                unique case (r_cnt)
                    CNT_0: begin
                        w_pend_nxt = in_data;
                        w_cnt_nxt  = CNT_1;
                    end
                    CNT_1: begin
                        w_out_a_nxt = {w_hi, w_lo};
                        w_cnt_nxt   = CNT_2;
                    end
                    CNT_2: begin
                        w_pend_nxt = in_data;
                        w_cnt_nxt  = CNT_3;
                    end
                    CNT_3: begin
                        w_out_b_nxt     = {w_hi, w_lo};
                        w_out_valid_nxt = 1'b1;
                        w_cnt_nxt       = CNT_0;
                    end
                    default: begin
                        w_cnt_nxt = CNT_0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pair_sort_loader.sv
module tb_pair_sort_loader;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] out_a;
  logic [2*WIDTH-1:0] out_b;
  logic               out_valid;
  logic               out_ready;

  int n_checks;
  int n_errors;

  pair_sort_loader #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present a sample and let one rising edge pass; in_valid stays high
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_group(input string tag, input logic [15:0] a, input logic [15:0] b);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_a"}, out_a, a);
    chk({tag, "_b"}, out_b, b);
  endtask

  initial begin
    logic [7:0] v;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // ---- reset state
    #2;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_a", out_a, 16'h0000);
    chk("rst_b", out_b, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

    // ---- basic group 7,3,9,1
    push(8'd7);
    push(8'd3);
    chk("t1_pairA_early", out_a, 16'h0703);
    chk("t1_valid_early", {15'd0, out_valid}, 16'd0);
    push(8'd9);
    push(8'd1);
    chk_group("t1", 16'h0703, 16'h0901);
    chk("t1_in_ready_hold", {15'd0, in_ready}, 16'd1);
    idle();
    chk("t1_valid_drop", {15'd0, out_valid}, 16'd0);

    // ---- ties and extremes 5,5,0,255
    push(8'd5);
    push(8'd5);
    push(8'd0);
    push(8'd255);
    chk_group("t2", 16'h0505, 16'hFF00);
    idle();
    chk("t2_valid_drop", {15'd0, out_valid}, 16'd0);

    // ---- backpressure 4,2,8,6 then 10 held
    out_ready = 1'b0;
    push(8'd4);
    push(8'd2);
    push(8'd8);
    push(8'd6);
    chk_group("t3", 16'h0402, 16'h0806);
    in_data = 8'd10;
    #1;
    chk("t3_in_ready_stall", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_group("t3_stall", 16'h0402, 16'h0806);
      chk("t3_stall_in_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_release", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    chk("t3_valid_after_xfer", {15'd0, out_valid}, 16'd0);
    // 10 was taken as s0 at the transfer edge
    push(8'd11);
    chk("t3_next_pairA", out_a, 16'h0B0A);
    push(8'd13);
    push(8'd12);
    chk_group("t3_next", 16'h0B0A, 16'h0D0C);
    idle();

    // ---- back-to-back 1..12
    for (int i = 1; i <= 12; i++) begin
      v = 8'(i);
      push(v);
      chk("t4_in_ready", {15'd0, in_ready}, 16'd1);
      if (i % 4 == 0) begin
        chk_group("t4", {8'(v - 8'd2), 8'(v - 8'd3)}, {v, 8'(v - 8'd1)});
      end else begin
        chk("t4_valid_low", {15'd0, out_valid}, 16'd0);
      end
    end
    idle();
    chk("t4_valid_drop", {15'd0, out_valid}, 16'd0);

    // ---- clear after partial group; sample in clear cycle dropped
    push(8'd9);
    push(8'd8);
    push(8'd7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    chk("t5_valid_after_clear", {15'd0, out_valid}, 16'd0);
    push(8'd1);
    chk("t5_no_partial_output", {15'd0, out_valid}, 16'd0);
    push(8'd2);
    push(8'd3);
    chk("t5_valid_3", {15'd0, out_valid}, 16'd0);
    push(8'd4);
    chk_group("t5", 16'h0201, 16'h0403);
    idle();

    // ---- async reset while holding
    out_ready = 1'b0;
    push(8'd4);
    push(8'd3);
    push(8'd2);
    push(8'd1);
    chk_group("t6_hold", 16'h0403, 16'h0201);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {15'd0, out_valid}, 16'd0);
    chk("t6_async_a", out_a, 16'h0000);
    chk("t6_async_b", out_b, 16'h0000);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t6_in_ready", {15'd0, in_ready}, 16'd1);
    push(8'd3);
    push(8'd1);
    push(8'd4);
    push(8'd2);
    chk_group("t6", 16'h0301, 16'h0402);
    idle();
    chk("t6_valid_drop", {15'd0, out_valid}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pair_sort_loader.md
Name: pair_sort_loader

Overview:
Upstream feeder for the 2-to-4 odd-even merge stage.
- Accepts a serial stream of unsigned WIDTH-bit samples (e.g. V2V distance/RSSI keys) over a valid/ready handshake.
- Groups every four accepted samples into two sorted pairs, a and b, each ascending (low lane = smaller).
- Presents both pairs in parallel, with a valid/ready handshake, directly on the merge stage's a/b inputs.

Parameters:
WIDTH, 8, bit width of one sample/key (unsigned compare)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: discard partial group and any held output
in_data  input  WIDTH  incoming sample
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
out_a  output  2*WIDTH  sorted pair A: [WIDTH-1:0]=min(s0,s1), [2*WIDTH-1:WIDTH]=max(s0,s1)
out_b  output  2*WIDTH  sorted pair B: [WIDTH-1:0]=min(s2,s3), [2*WIDTH-1:WIDTH]=max(s2,s3)
out_valid  output  1  out_a/out_b hold a complete group
out_ready  input  1  downstream consumes group this cycle

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async, any time, including mid-group or while holding):
  - out_a, out_b, out_valid = 0.
  - Internal count = 0, pending-sample register = 0.
  - in_ready = 1 once rst_n deasserts.
- Accept event: in_valid & in_ready at a rising edge. Output transfer event: out_valid & out_ready at a rising edge.
- State: 2-bit cnt (0..3, samples of current group already taken) plus 1-bit out_valid register.
  - FILL: out_valid = 0.
  - HOLD: out_valid = 1.
- in_ready = !out_valid | out_ready (combinational from out_ready; no other dependency).
- Per accept, by cnt:
  - cnt=0 or cnt=2: store sample in pending register.
  - cnt=1: out_a low lane <= min(pending, in_data); high lane <= max(pending, in_data).
  - cnt=3: out_b low lane <= min(pending, in_data); high lane <= max(pending, in_data); out_valid <= 1.
  - cnt increments modulo 4.
- Compare is unsigned. Ties (equal values): both lanes get the same value; no ordering ambiguity visible.
- Latency: the 4th sample accepted at edge k gives out_valid = 1 in the cycle after edge k. Pair A is already registered after the 2nd sample.
- HOLD behaviour:
  - out_a, out_b, out_valid stay stable until the transfer event.
  - Writes into out_a/out_b occur only while out_valid = 0, or in the same edge as a transfer.
  - Transfer without simultaneous accept: out_valid <= 0.
  - Transfer with simultaneous accept (cnt is 0 then): sample stored as s0 of the next group; out_valid <= 0.
  - out_a/out_b may then change on later accepts. Downstream must sample only on transfer.
- Throughput: 1 sample/cycle sustained; one group per 4 cycles with out_ready tied high. No bubble between groups.
- Backpressure: out_valid=1 & out_ready=0 gives in_ready=0; upstream stalls and no sample is lost.
- clear (synchronous, highest priority after reset):
  - Next state: cnt=0, out_valid=0.
  - A sample presented in the clear cycle is dropped, even if in_ready=1.
  - out_a/out_b data may retain old values.
- in_valid with in_ready=0: no state change.
- out_ready while out_valid=0: ignored.

Test Plan:
- WIDTH=8, out_ready=1, stream 7,3,9,1 on consecutive cycles -> one cycle after 4th accept: out_valid=1, out_a=16'h0703, out_b=16'h0901; out_valid=0 next cycle.
- Stream 5,5,0,255 -> out_a=16'h0505, out_b=16'hFF00 (tie and extreme-value handling).
- Backpressure: out_ready=0, stream 4,2,8,6,10 with in_valid held -> after 4 accepts in_ready=0; 10 is held, outputs stay 16'h0402/16'h0806 for 5 stall cycles. Raise out_ready -> transfer and 10 accepted at the same edge; next group starts with s0=10.
- Back-to-back: 12 samples 1..12 with out_ready=1 -> three groups at cycles 4, 8, 12: {0201,0403}, {0605,0807}, {0A09,0C0B}. in_ready never drops.
- clear after 3 samples (9,8,7), then stream 1,2,3,4 -> single group out_a=16'h0201, out_b=16'h0403; no output from the partial group.
- Assert rst_n=0 asynchronously mid-clock while HOLD -> out_valid, out_a, out_b go 0 immediately, not waiting for an edge. After release, stream 3,1,4,2 -> out_a=16'h0301, out_b=16'h0402.
